alu_exec_seq: RTL and testbench

Parametrised ALU instruction sequencer. It steps one register-register or register-immediate ALU instruction through operand fetch, execute, result latch and optional register write-back. It sits between the instruction decoder and the register-file/ALU bus controls, and is the configurable successor to the fixed 8-bit ALU FSM. It adds a synchronous start handshake, busy/done signalling, an immediate-operand mode and a no-write-back (compare-class) mode.

---
 rtl/alu_exec_seq.sv | 176 +++++++++++++++++
 tb/tb_alu_exec_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_seq
// Brief    : Parametrised ALU instruction sequencer. Walks one reg-reg or
//            reg-imm ALU instruction through operand fetch, execute, result
//            latch and optional write-back, with start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_seq #(
    parameter int               DATA_W  = 8,
    parameter int               RSEL_W  = 6,
    parameter int               OP_W    = 4,
    parameter logic [OP_W-2:0]  NOWB_OP = 3'b111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   opcode,
    input  logic [RSEL_W-1:0] param1,
    input  logic [RSEL_W-1:0] param2,
    output logic              busy,
    output logic              done,
    output logic [RSEL_W-1:0] rsel,
    output logic              rx1out,
    output logic              rx2out,
    output logic              immEN,
    output logic [DATA_W-1:0] immBus,
    output logic              ALUin0,
    output logic              ALUin1,
    output logic [OP_W-2:0]   opControl,
    output logic              ALUoutlatch,
    output logic              ALUoutEN,
    output logic              rxin,
    output logic              pcInc
);

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_FETCH_A  = 4'd1;
    localparam logic [3:0] c_LATCH_A  = 4'd2;
    localparam logic [3:0] c_FETCH_B  = 4'd3;
    localparam logic [3:0] c_LATCH_B  = 4'd4;
    localparam logic [3:0] c_EXEC     = 4'd5;
    localparam logic [3:0] c_RESULT   = 4'd6;
    localparam logic [3:0] c_WB_DRIVE = 4'd7;
    localparam logic [3:0] c_WB_WRITE = 4'd8;
    localparam logic [3:0] c_DONE     = 4'd9;

    logic [3:0]        r_state;
    logic [3:0]        w_next;
    logic [OP_W-1:0]   r_opcode;
    logic [RSEL_W-1:0] r_param1;
    logic [RSEL_W-1:0] r_param2;
    logic [OP_W-2:0]   w_op;
    logic              w_imm_mode;
    logic              w_nowb;
    logic [DATA_W-1:0] w_imm;

    assign w_op       = r_opcode[OP_W-1:1];
    assign w_imm_mode = r_opcode[0];
    assign w_nowb     = (w_op == NOWB_OP);

    // Immediate is zero-extended, or truncated when the select field is wider
    generate
        if (RSEL_W >= DATA_W) begin : g_imm_trunc
            assign w_imm = r_param2[DATA_W-1:0];
        end else begin : g_imm_zext
            assign w_imm = {{(DATA_W-RSEL_W){1'b0}}, r_param2};
        end
    endgenerate

    // Capture the instruction on acceptance so inputs may change afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opcode <= '0;
            r_param1 <= '0;
            r_param2 <= '0;
        end else if (r_state == c_IDLE && start) begin
            r_opcode <= opcode;
            r_param1 <= param1;
            r_param2 <= param2;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: fixed walk, compare-class ops skip the write-back pair
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:     w_next = start ? c_FETCH_A : c_IDLE;
            c_FETCH_A:  w_next = c_LATCH_A;
            c_LATCH_A:  w_next = c_FETCH_B;
            c_FETCH_B:  w_next = c_LATCH_B;
            c_LATCH_B:  w_next = c_EXEC;
            c_EXEC:     w_next = c_RESULT;
            c_RESULT:   w_next = w_nowb ? c_DONE : c_WB_DRIVE;
            c_WB_DRIVE: w_next = c_WB_WRITE;
            c_WB_WRITE: w_next = c_DONE;
            c_DONE:     w_next = c_IDLE;
            default:    w_next = c_IDLE;
        endcase
    end

    // Moore output decode; everything defaults low so nothing goes stale
    always_comb begin
        busy        = (r_state != c_IDLE);
        done        = 1'b0;
        rsel        = '0;
        rx1out      = 1'b0;
        rx2out      = 1'b0;
        immEN       = 1'b0;
        immBus      = '0;
        ALUin0      = 1'b0;
        ALUin1      = 1'b0;
        opControl   = '0;
        ALUoutlatch = 1'b0;
        ALUoutEN    = 1'b0;
        rxin        = 1'b0;
        pcInc       = 1'b0;
        case (r_state)
            c_FETCH_A: begin
                rx1out = 1'b1;
                rsel   = r_param1;
                pcInc  = 1'b1;
            end
            c_LATCH_A: begin
                rx1out = 1'b1;
                rsel   = r_param1;
                ALUin0 = 1'b1;
            end
            c_FETCH_B, c_LATCH_B: begin
                if (w_imm_mode) begin
                    immEN  = 1'b1;
                    immBus = w_imm;
                end else begin
                    rx2out = 1'b1;
                    rsel   = r_param2;
                end
                ALUin1 = (r_state == c_LATCH_B);
            end
            c_EXEC: begin
                opControl = w_op;
            end
            c_RESULT: begin
                opControl   = w_op;
                ALUoutlatch = 1'b1;
            end
            c_WB_DRIVE: begin
                opControl = w_op;
                ALUoutEN  = 1'b1;
                rsel      = r_param1;
            end
            c_WB_WRITE: begin
                opControl = w_op;
                ALUoutEN  = 1'b1;
                rxin      = 1'b1;
                rsel      = r_param1;
            end
            c_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = (r_state != c_IDLE);
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_seq
// Brief    : Self-checking bench for alu_exec_seq. Expected per-cycle output
//            records are queued at instruction acceptance and compared on the
//            falling edge; an empty queue means all outputs must be idle/zero.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_seq;

    localparam int DATA_W = 8;
    localparam int RSEL_W = 6;
    localparam int OP_W   = 4;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic [RSEL_W-1:0] rsel;
        logic              rx1;
        logic              rx2;
        logic              imm_en;
        logic [DATA_W-1:0] imm_bus;
        logic              a0;
        logic              a1;
        logic [OP_W-2:0]   opc;
        logic              olatch;
        logic              oen;
        logic              rxin;
        logic              pcinc;
    } out_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [OP_W-1:0]   opcode;
    logic [RSEL_W-1:0] param1;
    logic [RSEL_W-1:0] param2;
    logic              busy, done, rx1out, rx2out, immEN, ALUin0, ALUin1;
    logic              ALUoutlatch, ALUoutEN, rxin, pcInc;
    logic [RSEL_W-1:0] rsel;
    logic [DATA_W-1:0] immBus;
    logic [OP_W-2:0]   opControl;

    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    out_t exp_q[$];

    alu_exec_seq dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .param1(param1), .param2(param2), .busy(busy), .done(done),
        .rsel(rsel), .rx1out(rx1out), .rx2out(rx2out), .immEN(immEN),
        .immBus(immBus), .ALUin0(ALUin0), .ALUin1(ALUin1),
        .opControl(opControl), .ALUoutlatch(ALUoutlatch),
        .ALUoutEN(ALUoutEN), .rxin(rxin), .pcInc(pcInc)
    );

    always #5 clk = ~clk;

    function automatic out_t sample();
        out_t s;
        s = '{busy, done, rsel, rx1out, rx2out, immEN, immBus, ALUin0,
              ALUin1, opControl, ALUoutlatch, ALUoutEN, rxin, pcInc};
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected cycle-by-cycle records of one instruction plus the IDLE after it
    task automatic push_instr(input logic [OP_W-1:0] op4,
                              input logic [RSEL_W-1:0] p1,
                              input logic [RSEL_W-1:0] p2);
        out_t r;
        logic [OP_W-2:0] op;
        op = op4[OP_W-1:1];
        r = '0; r.busy = 1; r.rx1 = 1; r.rsel = p1; r.pcinc = 1; exp_q.push_back(r);
        r = '0; r.busy = 1; r.rx1 = 1; r.rsel = p1; r.a0 = 1;    exp_q.push_back(r);
        r = '0; r.busy = 1;
        if (op4[0]) begin
            r.imm_en = 1; r.imm_bus = {{(DATA_W-RSEL_W){1'b0}}, p2};
        end else begin
            r.rx2 = 1; r.rsel = p2;
        end
        exp_q.push_back(r);
        r.a1 = 1; exp_q.push_back(r);
        r = '0; r.busy = 1; r.opc = op; exp_q.push_back(r);
        r.olatch = 1; exp_q.push_back(r);
        if (op != 3'b111) begin
            r = '0; r.busy = 1; r.opc = op; r.oen = 1; r.rsel = p1; exp_q.push_back(r);
            r.rxin = 1; exp_q.push_back(r);
        end
        r = '0; r.busy = 1; r.done = 1; exp_q.push_back(r);
        r = '0; exp_q.push_back(r);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive an instruction while idle, release start after acceptance and scramble inputs
    task automatic issue(input logic [OP_W-1:0] op4, input logic [RSEL_W-1:0] p1,
                         input logic [RSEL_W-1:0] p2);
        opcode = op4; param1 = p1; param2 = p2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_instr(op4, p1, p2);
        opcode = OP_W'($urandom); param1 = RSEL_W'($urandom); param2 = RSEL_W'($urandom);
    endtask

    // Per-cycle scoreboard compare, bus-driver exclusivity and done counting
    always @(negedge clk) begin
        out_t obs;
        out_t exp;
        obs = sample();
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : out_t'(0);
        check("cycle_outputs", {4'b0, obs}, {4'b0, exp});
        check("bus_exclusive",
              {31'b0, ($countones({rx1out, rx2out, immEN, ALUoutEN}) <= 1)}, 32'd1);
        if (done) done_cnt++;
    end

    initial begin
        int base;
        logic [OP_W-1:0]   op_s;
        logic [RSEL_W-1:0] p1_s, p2_s;
        rst = 1'b1; start = 1'b0; opcode = '0; param1 = '0; param2 = '0;
        wait_cycles(3);
        check("reset_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        wait_cycles(2);

        // Register mode, write-back to param1
        issue(4'b0100, 6'd5, 6'd9);
        wait_cycles(9);
        // Immediate mode
        issue(4'b0011, 6'd12, 6'h2A);
        wait_cycles(9);
        // Compare-class op: no write-back, done in cycle 7
        issue(4'b1110, 6'd3, 6'd4);
        wait_cycles(7);
        wait_cycles(1);

        // start pulses during an active instruction must be ignored
        issue(4'b1010, 6'd7, 6'd33);
        wait_cycles(1);
        start = 1'b1; opcode = 4'b1110; param1 = 6'd1; param2 = 6'd2;
        wait_cycles(1);
        start = 1'b0; opcode = 4'b0001; param1 = 6'd60; param2 = 6'd61;
        wait_cycles(6);
        start = 1'b1; opcode = 4'b0111; param1 = 6'd17; param2 = 6'd18;
        wait_cycles(1);
        start = 1'b0;
        wait_cycles(3);

        // Asynchronous reset in the middle of WB_WRITE
        issue(4'b0100, 6'd5, 6'd9);
        wait_cycles(7);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {4'b0, sample()}, 32'd0);
        check("async_reset_busy", {31'b0, busy}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_cycles(3);

        // start held high for 30 cycles: three back-to-back instructions
        base = done_cnt;
        opcode = 4'b0100; param1 = 6'd5; param2 = 6'd9; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            op_s = opcode; p1_s = param1; p2_s = param2;
            @(posedge clk);
            #1;
            push_instr(op_s, p1_s, p2_s);
            opcode = (k == 0) ? 4'b0011 : 4'b1000;
            param1 = RSEL_W'(20 + k);
            param2 = RSEL_W'(40 + k);
            repeat (9) @(posedge clk);
        end
        #1;
        start = 1'b0;
        wait_cycles(3);
        check("held_start_done_count", 32'(done_cnt - base), 32'd3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
